// File: rtl/mul_result_bcd_converter_if.sv
// ---------------------------------------------------------------------------
// mul_result_bcd_converter_if
//
// Purpose: groups the request/result signals of the binary-to-BCD converter
//          so the converter and its driver share one bundle.
//
// Signals:
//   start    master -> slave  request a conversion (sampled on rising edge)
//   bin_in   master -> slave  binary value, WIDTH bits, sampled with start
//   busy     slave -> master  conversion in progress
//   done     slave -> master  one-cycle pulse, bcd_out just updated
//   bcd_out  slave -> master  packed BCD result, 4*DIGITS bits, MSD on top
//
// Modports: master (the multiplier/controller side), slave (the converter).
// ---------------------------------------------------------------------------
interface mul_result_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/mul_result_bcd_converter.sv
// ---------------------------------------------------------------------------
// mul_result_bcd_converter
//
// Purpose: sequential binary-to-BCD converter (shift-add-3 / double dabble)
//          for the 16-bit product of the 8x8 multiplier. One binary bit is
//          consumed per clock; a conversion takes WIDTH cycles from the edge
//          that accepts start to the edge that raises done.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous assert, active-low reset
//   bus    slave modport of mul_result_bcd_converter_if
//            start/bin_in in, busy/done/bcd_out out (all outputs registered)
//
// Parameters:
//   WIDTH  binary operand width
//   DIGITS BCD digit count; 10**DIGITS must exceed 2**WIDTH - 1
// ---------------------------------------------------------------------------
module mul_result_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mul_result_bcd_converter_if.slave      bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;

    // Scratch digits after the add-3 correction, and the next shift values.
    logic [BCD_W-1:0]   adj_scratch;
    logic [BCD_W-1:0]   scratch_d;
    logic [WIDTH-1:0]   bin_d;
    // The top bit of the corrected scratch falls off the shift; with a valid
    // DIGITS choice it is always zero.
    logic               unused_adj_msb;

    // Each nibble is corrected independently: a digit >= 5 would become >= 10
    // after doubling, so adding 3 first makes the carry land in the next digit.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
            always_comb begin
                if (scratch_q[4*gi +: 4] >= 4'd5) begin
                    adj_scratch[4*gi +: 4] = scratch_q[4*gi +: 4] + 4'd3;
                end else begin
                    adj_scratch[4*gi +: 4] = scratch_q[4*gi +: 4];
                end
            end
        end
    endgenerate

    // {scratch, binary} shifted left as one register; binary MSB enters
    // scratch bit 0.
    assign {unused_adj_msb, scratch_d, bin_d} = {adj_scratch, bin_q, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bin_q     <= bus.bin_in;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // start and bin_in are deliberately not looked at here.
                    scratch_q <= scratch_d;
                    bin_q     <= bin_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= scratch_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_mul_result_bcd_converter.sv
module tb_mul_result_bcd_converter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mul_result_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

    mul_result_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference built with division, independent of shift-add-3.
    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Pulse start for one cycle; returns at the negedge after the accepting edge.
    task automatic start_conv(input logic [15:0] v);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = v;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Count cycles until done (bounded); also counts busy-high samples.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!bus.done && cycles < 40) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic convert_check(input string tag, input logic [15:0] v, input logic [19:0] exp);
        int cyc, bcyc;
        start_conv(v);
        wait_done(cyc, bcyc);
        check({tag, "_lat"}, 32'(cyc), 32'd16);
        check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
        $display("conv %s bin=%0d bcd=%05h cycles=%0d", tag, v, bus.bcd_out, cyc);
    endtask

    initial begin
        int cyc, bcyc, ndone;
        int av[11];
        int bv[7];
        checks     = 0;
        failures   = 0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero: also check busy high for exactly 16 cycles.
        start_conv(16'd0);
        wait_done(cyc, bcyc);
        check("zero_lat", 32'(cyc), 32'd16);
        check("zero_busy_cycles", 32'(bcyc), 32'd16);
        check("zero_bcd", 32'(bus.bcd_out), 32'h00000);
        $display("conv zero bin=0 bcd=%05h cycles=%0d", bus.bcd_out, cyc);
        @(negedge clk);

        convert_check("ffff", 16'hFFFF, 20'h65535);
        convert_check("12345", 16'd12345, 20'h12345);
        convert_check("9999", 16'd9999, 20'h09999);
        convert_check("1000", 16'd1000, 20'h01000);
        convert_check("59", 16'd59, 20'h00059);

        // Product subset sweep against the division reference.
        av = '{0, 1, 2, 7, 9, 10, 99, 127, 128, 200, 255};
        bv = '{0, 1, 3, 9, 100, 254, 255};
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < 7; j++) begin
                convert_check($sformatf("p%0dx%0d", av[i], bv[j]),
                              16'(av[i] * bv[j]), to_bcd(av[i] * bv[j]));
            end
        end

        // start during SHIFT is ignored.
        start_conv(16'd500);
        repeat (4) @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 16'd777;
        @(negedge clk);
        bus.start  = 1'b0;
        cyc = 5;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ign_lat", 32'(cyc), 32'd16);
        check("ign_bcd", 32'(bus.bcd_out), 32'h00500);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("ign_no_second_done", 32'(ndone), 32'd0);
        check("ign_idle_busy", 32'(bus.busy), 32'd0);
        $display("conv ignore bin=500 bcd=%05h extra_done=%0d", bus.bcd_out, ndone);

        // Back-to-back: start accepted on the done cycle.
        start_conv(16'd42);
        wait_done(cyc, bcyc);
        check("b2b_first_bcd", 32'(bus.bcd_out), 32'h00042);
        bus.start  = 1'b1;
        bus.bin_in = 16'd100;
        @(negedge clk);
        bus.start  = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(cyc, bcyc);
        check("b2b_second_lat", 32'(cyc), 32'd16);
        check("b2b_second_bcd", 32'(bus.bcd_out), 32'h00100);
        $display("conv b2b bin=100 bcd=%05h cycles=%0d", bus.bcd_out, cyc);
        @(negedge clk);

        // Hold check: bcd_out keeps old value during a conversion.
        start_conv(16'd7);
        repeat (8) @(negedge clk);
        check("hold_mid_bcd", 32'(bus.bcd_out), 32'h00100);
        wait_done(cyc, bcyc);
        check("hold_final_bcd", 32'(bus.bcd_out), 32'h00007);
        @(negedge clk);

        // Asynchronous reset mid-conversion.
        start_conv(16'd4321);
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_bcd", 32'(bus.bcd_out), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        check("arst_bcd_after", 32'(bus.bcd_out), 32'd0);
        $display("conv abort bin=4321 bcd=%05h done_count=%0d", bus.bcd_out, ndone);

        // Converter still works after the abort.
        convert_check("post_rst", 16'd4321, 20'h04321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_result_bcd_converter.md
# mul_result_bcd_converter

Sequential binary-to-BCD converter that takes the 16-bit product from the 8x8 multiplier and produces packed decimal digits for the calculator's display and readout path. It sits directly downstream of the multiplier. It captures the product on a `start` pulse and runs a shift-add-3 (double-dabble) conversion, one bit per clock. It signals completion with a single-cycle `done` and holds the result stable until the next conversion completes.

## Interface
- `WIDTH`, default 16: binary operand width; matches the multiplier output.
- `DIGITS`, default 5: BCD digit count. Must satisfy 10^DIGITS > 2^WIDTH − 1; 5 digits cover 65535.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: request a conversion; sampled on rising edge.
- `bin_in`  in  WIDTH: binary value (multiplier product); sampled only on an accepted `start`.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when `bcd_out` has been updated.
- `bcd_out`  out  4*DIGITS: packed BCD result, most significant digit in the top nibble. For example, 12345 → 20'h12345.

## Operation
- Reset (`rst_n`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `bcd_out`=0, shift register and bit counter cleared.
- FSM states: IDLE, SHIFT.
- IDLE:
  - `start`=1 → latch `bin_in` into the binary shift register, clear the BCD scratch register, load counter = WIDTH, go to SHIFT.
  - `start`=0 → remain in IDLE.
- SHIFT, each cycle:
  - For every scratch digit ≥ 5, add 3 to it. Each nibble is adjusted independently; digits never exceed 4'h9 after the shift.
  - Shift {scratch, binary} left by 1 as one combined register; the binary MSB enters scratch bit 0.
  - Decrement the counter.
- Last shift (counter = 1):
  - Load `bcd_out` with the post-shift scratch value.
  - Pulse `done`.
  - Return to IDLE.
- `start` while in SHIFT is ignored; it is neither queued nor restarts the conversion, and `bin_in` changes are not observed.
- `bcd_out` is not cleared on `start`. It keeps the previous result until the new conversion's completion edge.
- `done` and `busy` are never high in the same cycle.
- Reset asserted mid-conversion aborts it: no `done`, and `bcd_out` returns to 0.
- All arithmetic is unsigned. There is no overflow path, because the `DIGITS` constraint guarantees the result fits.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
- `busy` goes high after E0.
- Shifts occur on edges E1..E_WIDTH.
- At E_WIDTH (E16 at default width):
  - `bcd_out` is updated.
  - `done`=1 for exactly one cycle.
  - `busy` returns to 0.
- Latency is WIDTH cycles from the start edge to `done` visible.
- Back-to-back conversions: a `start` sampled in the cycle `done` is high is accepted, because the FSM is already in IDLE. Sustained throughput is one conversion per WIDTH+1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `bin_in`=16'd0 with `start` pulse → `done` 16 cycles after the start edge, `bcd_out`=20'h00000, `busy` high for exactly 16 cycles.
- `bin_in`=16'hFFFF → `bcd_out`=20'h65535. `bin_in`=16'd12345 → 20'h12345. `bin_in`=16'd9999 (99×101) → 20'h09999.
- Sweep all 8-bit × 8-bit products (feed multiplier output) → `bcd_out` matches the decimal reference for every case; `done` pulses exactly once per start.
- Start with 16'd500; at cycle 5 assert `start` with `bin_in`=16'd777 → ignored; result 20'h00500 at cycle 16; no second `done`.
- Start 16'd42; on its `done` cycle assert `start` with 16'd100 → second `done` 16 cycles later with 20'h00100. `bcd_out` holds 20'h00042 until then.
- Start 16'd4321; at cycle 8 pulse `rst_n`=0 asynchronously (mid-cycle) → immediately `busy`=0, `bcd_out`=0; no `done` ever fires for the aborted conversion.
